// File: rtl/sd_host_data_phy_pkg.sv
// Shared constants for the host-side SD 4-bit data PHY: state codes, CRC16 and CRC status tokens.
package sd_host_data_phy_pkg;

  localparam int unsigned CRC_BITS = 16;
  localparam int unsigned COUNT_W  = 13;
  localparam int unsigned TMO_W    = 16;
  localparam int unsigned LINES    = 4;

  localparam logic [CRC_BITS-1:0] CRC16_POLY = 16'h1021;

  localparam logic [2:0] TOKEN_ACCEPTED = 3'b010;
  localparam logic [2:0] TOKEN_CRC_ERR  = 3'b101;
  localparam logic [2:0] TOKEN_WR_ERR   = 3'b110;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_TX_START  = 4'd1;
  localparam logic [3:0] ST_TX_DATA   = 4'd2;
  localparam logic [3:0] ST_TX_CRC    = 4'd3;
  localparam logic [3:0] ST_TX_END    = 4'd4;
  localparam logic [3:0] ST_STAT_WAIT = 4'd5;
  localparam logic [3:0] ST_STAT_CAP  = 4'd6;
  localparam logic [3:0] ST_STAT_END  = 4'd7;
  localparam logic [3:0] ST_BUSY      = 4'd8;
  localparam logic [3:0] ST_RX_WAIT   = 4'd9;
  localparam logic [3:0] ST_RX_DATA   = 4'd10;
  localparam logic [3:0] ST_RX_CRC    = 4'd11;
  localparam logic [3:0] ST_RX_END    = 4'd12;
  localparam logic [3:0] ST_FINISHED  = 4'd13;

  typedef struct packed {
    logic       crc_good;
    logic       timeout;
    logic [2:0] status;
  } result_t;

endpackage

// File: rtl/sd_host_data_phy_if.sv
// Controller/FIFO side of the SD host data PHY: transfer control, byte FIFOs and result flags.
interface sd_host_data_phy_if;
  import sd_host_data_phy_pkg::*;

  logic               i_activate;
  logic               i_write_flag;
  logic [COUNT_W-1:0] i_data_count;
  logic               o_data_rd_stb;
  logic [7:0]         i_data_rd_data;
  logic               o_data_wr_stb;
  logic [7:0]         o_data_wr_data;
  logic               o_finished;
  logic               o_crc_good;
  logic               o_timeout;
  logic [2:0]         o_status;

  modport master (
    output i_activate, i_write_flag, i_data_count, i_data_rd_data,
    input  o_data_rd_stb, o_data_wr_stb, o_data_wr_data,
    input  o_finished, o_crc_good, o_timeout, o_status
  );

  modport slave (
    input  i_activate, i_write_flag, i_data_count, i_data_rd_data,
    output o_data_rd_stb, o_data_wr_stb, o_data_wr_data,
    output o_finished, o_crc_good, o_timeout, o_status
  );

endinterface

// File: rtl/sd_host_data_phy_crc.sv
// Serial CRC16-CCITT generator for one DAT line, MSB first, zero init.
module sd_crc16_serial
  import sd_host_data_phy_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic                bit_i,
  output logic [CRC_BITS-1:0] crc_o
);

  logic [CRC_BITS-1:0] crc_q, crc_d;
  logic                fb_c;

  always_comb begin
    fb_c  = bit_i ^ crc_q[CRC_BITS-1];
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = {crc_q[CRC_BITS-2:0], 1'b0} ^ ({CRC_BITS{fb_c}} & CRC16_POLY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_host_data_phy.sv
// Host-side SD 4-bit data engine: write framing with CRC status/busy handling, read capture with CRC check.
module sd_host_data_phy
  import sd_host_data_phy_pkg::*;
#(
  parameter int unsigned START_TIMEOUT = 1024,
  parameter int unsigned BUSY_TIMEOUT  = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  sd_host_data_phy_if.slave    bus,
  output logic                 o_sd_data_oe,
  output logic [LINES-1:0]     o_sd_data_out,
  input  logic [LINES-1:0]     i_sd_data_in
);

  logic [3:0]                          state_q, state_d;
  logic [COUNT_W-1:0]                  left_q, left_d;
  logic                                phase_q, phase_d;
  logic [TMO_W-1:0]                    tmo_q, tmo_d;
  logic [3:0]                          idx_q, idx_d;
  logic [7:0]                          byte_q, byte_d;
  logic [LINES-1:0][CRC_BITS-1:0]      rcrc_q, rcrc_d;
  logic                                oe_q, oe_d;
  logic [LINES-1:0]                    dout_q, dout_d;
  logic                                rd_stb_q, rd_stb_d;
  logic                                wr_stb_q, wr_stb_d;
  logic [7:0]                          wr_data_q, wr_data_d;
  logic                                finished_q, finished_d;
  result_t                             res_q, res_d;
  logic                                crc_en_c, crc_clr_c;
  logic [LINES-1:0]                    crc_bit_c;
  logic [LINES-1:0][CRC_BITS-1:0]      crc_c;

  for (genvar l = 0; l < LINES; l++) begin : g_crc
    sd_crc16_serial u_crc (
      .clk   (clk),
      .rst   (rst),
      .en_i  (crc_en_c),
      .clr_i (crc_clr_c),
      .bit_i (crc_bit_c[l]),
      .crc_o (crc_c[l])
    );
  end

  // Bus outputs are registered, so pad activity trails the state register by one clock.
  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    phase_d    = phase_q;
    tmo_d      = '0;
    idx_d      = '0;
    byte_d     = byte_q;
    rcrc_d     = rcrc_q;
    oe_d       = oe_q;
    dout_d     = dout_q;
    rd_stb_d   = 1'b0;
    wr_stb_d   = 1'b0;
    wr_data_d  = wr_data_q;
    finished_d = finished_q;
    res_d      = res_q;
    crc_en_c   = 1'b0;
    crc_clr_c  = 1'b0;
    crc_bit_c  = '0;

    if (state_q != ST_IDLE && !bus.i_activate) begin
      state_d    = ST_IDLE;
      oe_d       = 1'b0;
      dout_d     = 4'hF;
      finished_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          crc_clr_c  = 1'b1;
          rcrc_d     = '0;
          oe_d       = 1'b0;
          dout_d     = 4'hF;
          finished_d = 1'b0;
          phase_d    = 1'b0;
          if (bus.i_activate) begin
            res_d  = '0;
            left_d = bus.i_data_count;
            if (bus.i_data_count == '0) begin
              state_d        = ST_FINISHED;
              finished_d     = 1'b1;
              res_d.crc_good = 1'b1;
            end else if (bus.i_write_flag) begin
              state_d  = ST_TX_START;
              rd_stb_d = 1'b1;
            end else begin
              state_d = ST_RX_WAIT;
            end
          end
        end
        ST_TX_START: begin
          oe_d    = 1'b1;
          dout_d  = 4'h0;
          state_d = ST_TX_DATA;
        end
        ST_TX_DATA: begin
          crc_en_c = 1'b1;
          if (!phase_q) begin
            byte_d    = bus.i_data_rd_data;
            crc_bit_c = bus.i_data_rd_data[7:4];
            rd_stb_d  = (left_q != COUNT_W'(1));
          end else begin
            crc_bit_c = byte_q[3:0];
            left_d    = left_q - COUNT_W'(1);
            if (left_q == COUNT_W'(1)) state_d = ST_TX_CRC;
          end
          dout_d  = crc_bit_c;
          phase_d = !phase_q;
        end
        ST_TX_CRC: begin
          for (int l = 0; l < LINES; l++) dout_d[l] = crc_c[l][4'd15 - idx_q];
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = ST_TX_END;
        end
        ST_TX_END: begin
          dout_d  = 4'hF;
          state_d = ST_STAT_WAIT;
        end
        // First two clocks are bus turnaround; DAT0 is not trusted there.
        ST_STAT_WAIT: begin
          oe_d  = 1'b0;
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q >= TMO_W'(2) && !i_sd_data_in[0]) begin
            state_d = ST_STAT_CAP;
          end else if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
            state_d       = ST_FINISHED;
            finished_d    = 1'b1;
            res_d.timeout = 1'b1;
          end
        end
        ST_STAT_CAP: begin
          res_d.status = {res_q.status[1:0], i_sd_data_in[0]};
          idx_d        = idx_q + 4'd1;
          if (idx_q == 4'd2) state_d = ST_STAT_END;
        end
        ST_STAT_END: state_d = ST_BUSY;
        ST_BUSY: begin
          tmo_d = tmo_q + TMO_W'(1);
          if (i_sd_data_in[0]) begin
            state_d        = ST_FINISHED;
            finished_d     = 1'b1;
            res_d.crc_good = (res_q.status == TOKEN_ACCEPTED);
          end else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
            state_d       = ST_FINISHED;
            finished_d    = 1'b1;
            res_d.timeout = 1'b1;
          end
        end
        ST_RX_WAIT: begin
          tmo_d = tmo_q + TMO_W'(1);
          if (i_sd_data_in == 4'h0) begin
            state_d = ST_RX_DATA;
            phase_d = 1'b0;
          end else if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
            state_d       = ST_FINISHED;
            finished_d    = 1'b1;
            res_d.timeout = 1'b1;
          end
        end
        ST_RX_DATA: begin
          crc_en_c  = 1'b1;
          crc_bit_c = i_sd_data_in;
          phase_d   = !phase_q;
          if (!phase_q) begin
            byte_d = {i_sd_data_in, byte_q[3:0]};
          end else begin
            wr_data_d = {byte_q[7:4], i_sd_data_in};
            wr_stb_d  = 1'b1;
            left_d    = left_q - COUNT_W'(1);
            if (left_q == COUNT_W'(1)) state_d = ST_RX_CRC;
          end
        end
        ST_RX_CRC: begin
          for (int l = 0; l < LINES; l++) rcrc_d[l] = {rcrc_q[l][CRC_BITS-2:0], i_sd_data_in[l]};
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = ST_RX_END;
        end
        ST_RX_END: begin
          state_d        = ST_FINISHED;
          finished_d     = 1'b1;
          res_d.crc_good = (i_sd_data_in == 4'hF) && (rcrc_q == crc_c);
        end
        ST_FINISHED: begin
          oe_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      left_q     <= '0;
      phase_q    <= 1'b0;
      tmo_q      <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      rcrc_q     <= '0;
      oe_q       <= 1'b0;
      dout_q     <= 4'hF;
      rd_stb_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_data_q  <= '0;
      finished_q <= 1'b0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      left_q     <= left_d;
      phase_q    <= phase_d;
      tmo_q      <= tmo_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      rcrc_q     <= rcrc_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
      rd_stb_q   <= rd_stb_d;
      wr_stb_q   <= wr_stb_d;
      wr_data_q  <= wr_data_d;
      finished_q <= finished_d;
      res_q      <= res_d;
    end
  end

  assign o_sd_data_oe       = oe_q;
  assign o_sd_data_out      = dout_q;
  assign bus.o_data_rd_stb  = rd_stb_q;
  assign bus.o_data_wr_stb  = wr_stb_q;
  assign bus.o_data_wr_data = wr_data_q;
  assign bus.o_finished     = finished_q;
  assign bus.o_crc_good     = res_q.crc_good;
  assign bus.o_timeout      = res_q.timeout;
  assign bus.o_status       = res_q.status;

endmodule

// File: tb/tb_sd_host_data_phy.sv
// Scoreboard bench for sd_host_data_phy: directed writes/reads with a card model on DAT[3:0].
module tb_sd_host_data_phy;
  import sd_host_data_phy_pkg::*;

  localparam int unsigned TB_START_TMO = 1024;
  localparam int unsigned TB_BUSY_TMO  = 3000;

  logic       clk;
  logic       rst;
  logic       oe;
  logic [3:0] dout;
  logic [3:0] din;

  sd_host_data_phy_if bus_if ();

  sd_host_data_phy #(
    .START_TIMEOUT (TB_START_TMO),
    .BUSY_TIMEOUT  (TB_BUSY_TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_if),
    .o_sd_data_oe  (oe),
    .o_sd_data_out (dout),
    .i_sd_data_in  (din)
  );

  always #5 clk = ~clk;

  int        errors = 0;
  int        checks = 0;
  int        rd_cnt = 0;
  int        wr_cnt = 0;
  int        fin_cnt = 0;
  logic      fin_seen = 1'b0;
  logic [7:0] tx_q[$];
  logic [3:0] exp_bus_q[$];
  logic [7:0] exp_wr_q[$];
  result_t    exp_res_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ (((b ^ c[15]) == 1'b1) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic calc_crc(input logic [7:0] b[$], output logic [3:0][15:0] c);
    logic [3:0] n;
    c = '0;
    foreach (b[i]) begin
      for (int h = 1; h >= 0; h--) begin
        n = (h == 1) ? b[i][7:4] : b[i][3:0];
        for (int l = 0; l < 4; l++) c[l] = crc_step(c[l], n[l]);
      end
    end
  endtask

  // Expected DAT nibbles for a write: start, data (high first), CRC, end.
  task automatic push_write(input logic [7:0] b[$]);
    logic [3:0][15:0] c;
    logic [3:0]       n;
    calc_crc(b, c);
    exp_bus_q.push_back(4'h0);
    foreach (b[i]) begin
      exp_bus_q.push_back(b[i][7:4]);
      exp_bus_q.push_back(b[i][3:0]);
      tx_q.push_back(b[i]);
    end
    for (int k = 0; k < 16; k++) begin
      for (int l = 0; l < 4; l++) n[l] = c[l][15-k];
      exp_bus_q.push_back(n);
    end
    exp_bus_q.push_back(4'hF);
  endtask

  // Bus monitor: every driven nibble must match the next expected one.
  always @(negedge clk) begin
    if (oe) begin
      if (exp_bus_q.size() == 0) check("bus_extra", 32'(dout), 32'hFFFF_FFFF);
      else                       check("bus_nibble", 32'(dout), 32'(exp_bus_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (bus_if.o_data_wr_stb) begin
      wr_cnt++;
      if (exp_wr_q.size() == 0) check("wr_extra", 32'(bus_if.o_data_wr_data), 32'hFFFF_FFFF);
      else                      check("wr_byte", 32'(bus_if.o_data_wr_data), 32'(exp_wr_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (bus_if.o_finished && !fin_seen) begin
      fin_seen = 1'b1;
      fin_cnt++;
      if (exp_res_q.size() == 0) check("fin_extra", 32'(bus_if.o_finished), 32'h0);
      else begin
        result_t r;
        r = exp_res_q.pop_front();
        check("crc_good", 32'(bus_if.o_crc_good), 32'(r.crc_good));
        check("timeout", 32'(bus_if.o_timeout), 32'(r.timeout));
        check("status", 32'(bus_if.o_status), 32'(r.status));
      end
    end else if (!bus_if.o_finished) begin
      fin_seen = 1'b0;
    end
  end

  // TX FIFO: a strobe makes the next byte available for the following clock.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.o_data_rd_stb) begin
        rd_cnt++;
        if (tx_q.size() != 0) bus_if.i_data_rd_data = tx_q.pop_front();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic wr, input int cnt);
    bus_if.i_write_flag = wr;
    bus_if.i_data_count = 13'(cnt);
    bus_if.i_activate   = 1'b1;
  endtask

  task automatic wait_fin(input int f0, input int budget);
    int n = 0;
    while (fin_cnt == f0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("finished_seen", 32'(fin_cnt != f0), 32'h1);
  endtask

  task automatic end_xfer();
    bus_if.i_activate = 1'b0;
    tick(2);
    check("finished_clear", 32'(bus_if.o_finished), 32'h0);
  endtask

  task automatic card_status(input logic [2:0] tok, input int busy);
    int n = 0;
    while (!oe && n < 50) begin @(negedge clk); n++; end
    check("oe_rise", 32'(oe), 32'h1);
    n = 0;
    while (oe && n < 2000) begin @(negedge clk); n++; end
    check("oe_fall", 32'(oe), 32'h0);
    tick(2);
    din = 4'hE; tick(1);
    for (int i = 2; i >= 0; i--) begin din = {3'b111, tok[i]}; tick(1); end
    din = 4'hF; tick(1);
    for (int i = 0; i < busy; i++) begin din = 4'hE; tick(1); end
    din = 4'hF;
  endtask

  task automatic card_read(input logic [7:0] b[$], input int flip_line, input int flip_k,
                           input logic [3:0] endn);
    logic [3:0][15:0] c;
    logic [3:0]       n;
    calc_crc(b, c);
    if (flip_line >= 0) c[flip_line][flip_k] = ~c[flip_line][flip_k];
    tick(3);
    din = 4'h0; tick(1);
    foreach (b[i]) begin
      din = b[i][7:4]; tick(1);
      din = b[i][3:0]; tick(1);
    end
    for (int k = 0; k < 16; k++) begin
      for (int l = 0; l < 4; l++) n[l] = c[l][15-k];
      din = n; tick(1);
    end
    din = endn; tick(1);
    din = 4'hF;
  endtask

  task automatic do_write(input logic [7:0] b[$], input logic [2:0] tok, input result_t r);
    int rd0 = rd_cnt;
    int f0  = fin_cnt;
    push_write(b);
    exp_res_q.push_back(r);
    start(1'b1, b.size());
    card_status(tok, 3);
    wait_fin(f0, 200);
    check("rd_strobes", 32'(rd_cnt - rd0), 32'(b.size()));
    check("bus_drained", 32'(exp_bus_q.size()), 32'h0);
    end_xfer();
  endtask

  task automatic do_read(input logic [7:0] b[$], input int fl, input int fk,
                         input logic [3:0] endn, input logic good);
    int w0 = wr_cnt;
    int f0 = fin_cnt;
    foreach (b[i]) exp_wr_q.push_back(b[i]);
    exp_res_q.push_back(result_t'{good, 1'b0, 3'b000});
    start(1'b0, b.size());
    card_read(b, fl, fk, endn);
    wait_fin(f0, 50);
    check("wr_strobes", 32'(wr_cnt - w0), 32'(b.size()));
    end_xfer();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oe"}, 32'(oe), 32'h0);
    check({tag, "_dout"}, 32'(dout), 32'hF);
    check({tag, "_fin"}, 32'(bus_if.o_finished), 32'h0);
    check({tag, "_good"}, 32'(bus_if.o_crc_good), 32'h0);
    check({tag, "_tmo"}, 32'(bus_if.o_timeout), 32'h0);
    check({tag, "_status"}, 32'(bus_if.o_status), 32'h0);
    check({tag, "_rdstb"}, 32'(bus_if.o_data_rd_stb), 32'h0);
    check({tag, "_wrstb"}, 32'(bus_if.o_data_wr_stb), 32'h0);
    check({tag, "_wrdata"}, 32'(bus_if.o_data_wr_data), 32'h0);
  endtask

  initial begin
    logic [7:0] b1[$];
    logic [7:0] b2[$];
    logic [7:0] b4[$];
    int         f0;
    int         rd0;
    int         w0;
    int         n;

    b1 = '{8'h00};
    b2 = '{8'hA5, 8'h3C};
    b4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    clk = 1'b0;
    rst = 1'b1;
    din = 4'hF;
    bus_if.i_activate     = 1'b0;
    bus_if.i_write_flag   = 1'b0;
    bus_if.i_data_count   = '0;
    bus_if.i_data_rd_data = '0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // Zero-length transfer completes immediately with crc_good.
    f0 = fin_cnt;
    exp_res_q.push_back(result_t'{1'b1, 1'b0, 3'b000});
    start(1'b1, 0);
    tick(1);
    check("count0_fin", 32'(bus_if.o_finished), 32'h1);
    wait_fin(f0, 10);
    end_xfer();

    do_write(b1, TOKEN_ACCEPTED, result_t'{1'b1, 1'b0, TOKEN_ACCEPTED});
    do_write(b2, TOKEN_CRC_ERR,  result_t'{1'b0, 1'b0, TOKEN_CRC_ERR});
    do_write(b2, TOKEN_WR_ERR,   result_t'{1'b0, 1'b0, TOKEN_WR_ERR});

    do_read(b1, -1, 0, 4'hF, 1'b1);
    do_read(b1, 2, 5, 4'hF, 1'b0);
    do_read(b1, -1, 0, 4'h7, 1'b0);
    do_read(b2, -1, 0, 4'hF, 1'b1);

    // Read with no start bit.
    f0 = fin_cnt;
    w0 = wr_cnt;
    exp_res_q.push_back(result_t'{1'b0, 1'b1, 3'b000});
    start(1'b0, 1);
    wait_fin(f0, TB_START_TMO + 100);
    check("rx_tmo_wr", 32'(wr_cnt - w0), 32'h0);
    end_xfer();

    // Write with DAT0 stuck low: token reads 000, then busy never ends.
    f0 = fin_cnt;
    din = 4'hE;
    push_write(b1);
    exp_res_q.push_back(result_t'{1'b0, 1'b1, 3'b000});
    start(1'b1, 1);
    wait_fin(f0, TB_BUSY_TMO + 200);
    din = 4'hF;
    end_xfer();

    // Abort in the middle of TX_DATA.
    f0  = fin_cnt;
    rd0 = rd_cnt;
    push_write(b4);
    start(1'b1, 4);
    n = 0;
    while ((rd_cnt - rd0) < 2 && n < 50) begin @(negedge clk); n++; end
    check("abort_reached", 32'(rd_cnt - rd0 >= 2), 32'h1);
    bus_if.i_activate = 1'b0;
    tick(1);
    check("abort_oe", 32'(oe), 32'h0);
    check("abort_rdstb", 32'(bus_if.o_data_rd_stb), 32'h0);
    tick(5);
    check("abort_nofin", 32'(fin_cnt - f0), 32'h0);
    check("abort_oe_hold", 32'(oe), 32'h0);
    exp_bus_q.delete();
    tx_q.delete();

    // Synchronous reset in the middle of a read.
    start(1'b0, 2);
    tick(3);
    din = 4'h0; tick(1);
    din = 4'hA; tick(1);
    rst = 1'b1;
    din = 4'hF;
    tick(1);
    check_reset_outputs("midrst");
    bus_if.i_activate = 1'b0;
    rst = 1'b0;
    tick(3);

    check("exp_bus_left", 32'(exp_bus_q.size()), 32'h0);
    check("exp_wr_left", 32'(exp_wr_q.size()), 32'h0);
    check("exp_res_left", 32'(exp_res_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_host_data_phy.md
Name: sd_host_data_phy

Overview:
- Host-side SD 4-bit data-line engine: the opposite end of the card-side data PHY.
- Write (host→card): drives start bit, data nibbles, per-line CRC16 and end bit; then receives the card's CRC status token on DAT0 and waits out busy.
- Read (card→host): detects the card start bit, assembles bytes, captures and checks per-line CRC16.
- Sits between the host transaction controller / byte FIFOs and the FPGA pad tristate for DAT[3:0]; SDR, one nibble per clk.

Parameters:
- START_TIMEOUT, 1024, clocks to wait for a read start bit or a CRC status start bit.
- BUSY_TIMEOUT, 65535, clocks DAT0 may be held low (busy) after a write.
- CRC_BITS, 16, CRC length per line; fixed, not to be overridden.

Ports:
- clk  in  1  SD clock domain clock
- rst  in  1  reset; synchronous, active-high
- i_activate  in  1  start transfer; must stay high until o_finished; drop = abort
- i_write_flag  in  1  1 = host write, 0 = host read; sampled in IDLE
- i_data_count  in  13  byte count; 0 = no-op
- o_data_rd_stb  out  1  pop one byte from TX FIFO (write direction)
- i_data_rd_data  in  8  TX byte; valid the cycle after o_data_rd_stb
- o_data_wr_stb  out  1  one RX byte valid on o_data_wr_data (read direction)
- o_data_wr_data  out  8  RX byte
- o_finished  out  1  transfer done; held until i_activate low
- o_crc_good  out  1  read: all 4 CRCs matched and end bit = 1; write: status token = 3'b010
- o_timeout  out  1  start or busy timeout hit
- o_status  out  3  captured CRC status token (write only)
- o_sd_data_oe  out  1  1 = host drives DAT[3:0]
- o_sd_data_out  out  4  DAT[3:0] drive value
- i_sd_data_in  in  4  DAT[3:0] sampled value

Behaviour:
- Reset values: all strobes/flags 0; o_status 0; o_data_wr_data 0; o_sd_data_oe 0; o_sd_data_out 4'hF; state IDLE; CRCs 0. Reset mid-transfer releases the bus the next cycle.
- Nibble order: high nibble first. DAT3 carries bit 7/3, DAT0 carries bit 4/0.
- CRC: CRC16-CCITT (x^16+x^12+x^5+1), init 0, one serial generator per line, MSB-first shift out. Cleared in IDLE.
- IDLE:
  - oe = 0, o_finished = 0.
  - On i_activate with i_data_count == 0: FINISHED next clk, o_crc_good = 1, no bus activity.
  - Otherwise go to TX_START if write, RX_WAIT if read.
- TX_START: oe = 1, drive 4'h0 for 1 clk. Assert o_data_rd_stb this clk so byte 0 is ready.
- TX_DATA:
  - Alternate high/low nibble each clk; both feed the CRCs.
  - o_data_rd_stb pulses on the high-nibble clk of every byte except the last, so the next byte is ready one clk ahead.
  - After 2·count clks go to TX_CRC.
- TX_CRC: 16 clks driving {crc3[15-k], crc2[15-k], crc1[15-k], crc0[15-k]}, then TX_END.
- TX_END: drive 4'hF for 1 clk, then oe = 0 and go to STAT_WAIT.
- STAT_WAIT:
  - Skip 2 clks of turnaround, then wait for DAT0 == 0.
  - Capture the next 3 DAT0 bits into o_status, MSB first, then 1 end-bit clk. Go to BUSY.
  - Timeout after START_TIMEOUT clks → o_timeout = 1, FINISHED.
- BUSY:
  - Wait for DAT0 == 1. o_crc_good = (o_status == 3'b010). Go to FINISHED.
  - Timeout after BUSY_TIMEOUT clks → o_timeout = 1, FINISHED.
- RX_WAIT:
  - Wait for i_sd_data_in == 4'h0; all 4 lines must be low.
  - Timeout after START_TIMEOUT clks → o_timeout = 1, FINISHED.
- RX_DATA:
  - Latch high nibble, then low nibble.
  - o_data_wr_stb = 1 for exactly 1 clk, 1 clk after the low nibble is sampled; byte is registered.
  - CRCs updated per nibble. After count bytes go to RX_CRC.
- RX_CRC: shift 16 clks into 4 remote CRC registers, then RX_END.
- RX_END: sample end nibble. o_crc_good = (end == 4'hF) && all 4 remote == generated. Go to FINISHED.
- FINISHED:
  - o_finished = 1, oe = 0, o_crc_good / o_timeout / o_status held.
  - On i_activate low: IDLE.
- Abort: i_activate low in any non-IDLE state → IDLE next clk, oe = 0, no strobes, o_finished not asserted.
- Counters: 13-bit byte counter, 1-bit nibble phase, 16-bit timeout counter, 4-bit CRC index. No wrap permitted; timeouts saturate to a transition.

Decomposition:
- Shared package: state encodings, CRC16 polynomial constant, status token constants (ACCEPTED = 3'b010, CRC_ERR = 3'b101, WR_ERR = 3'b110), CRC_BITS.
- Sub-module: sd_crc16_serial (clk, rst, en, bit, crc[15:0]), instantiated 4×, one per DAT line.

Test Plan:
- Write, count = 1, byte 8'h00, card returns DAT0 token 0,0,1,0,1 then 3 busy clks → bus shows 0x0, 0x0, 0x0, sixteen 0x0 CRC nibbles, 0xF; o_status = 3'b010; o_crc_good = 1; o_finished after busy release.
- Write, count = 2, bytes A5, 3C → DAT sequence 0, A, 5, 3, C, CRC, F; exactly 2 o_data_rd_stb pulses; card token 101 → o_status = 3'b101, o_crc_good = 0.
- Read, count = 1, card drives 0, then nibbles 0, 0, then sixteen 0x0, then 0xF → one o_data_wr_stb with 8'h00; o_crc_good = 1.
- Read with one CRC bit flipped on DAT2, and separately end nibble 0x7 → o_crc_good = 0 in both cases.
- Read, no start bit for START_TIMEOUT clks → o_timeout = 1, o_finished = 1, zero wr strobes. Write with DAT0 held low → o_timeout after BUSY_TIMEOUT.
- Abort: i_activate dropped mid TX_DATA → oe = 0 next clk, IDLE, no o_finished. Then rst asserted mid read → all outputs at reset values next clk.
